// File: rtl/rf_write_arbiter.sv
// Round-robin arbiter sharing the register-file write port between the ALU and
// memory writeback paths, with a one-cycle registered write and RAW hazard flag.
module rf_write_arbiter #(
  parameter int WD_SIZE        = 32,
  parameter int INSTR_REG_BITS = 5,
  parameter int CNT_BITS       = 16
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      alu_valid,
  input  logic [INSTR_REG_BITS-1:0] alu_rd,
  input  logic [WD_SIZE-1:0]        alu_data,
  output logic                      alu_ready,
  input  logic                      mem_valid,
  input  logic [INSTR_REG_BITS-1:0] mem_rd,
  input  logic [WD_SIZE-1:0]        mem_data,
  output logic                      mem_ready,
  input  logic [INSTR_REG_BITS-1:0] rs1,
  input  logic [INSTR_REG_BITS-1:0] rs2,
  output logic                      hazard,
  output logic [INSTR_REG_BITS-1:0] wr_rd,
  output logic [WD_SIZE-1:0]        wr_data,
  output logic [CNT_BITS-1:0]       conflict_cnt
);

  typedef enum logic {PRIO_ALU = 1'b0, PRIO_MEM = 1'b1} prio_e;

  prio_e                     prio_q, prio_d;
  logic [INSTR_REG_BITS-1:0] wr_rd_q, wr_rd_d;
  logic [WD_SIZE-1:0]        wr_data_q, wr_data_d;
  logic [CNT_BITS-1:0]       cnt_q, cnt_d;

  logic alu_real, mem_real, alu_null, mem_null;
  logic grant_alu, grant_mem;

  // An operand is hazardous while its write is requested or sitting in the output stage.
  function automatic logic rs_hazard(input logic [INSTR_REG_BITS-1:0] rs);
    return (rs != '0) &&
           ((alu_real && (rs == alu_rd)) ||
            (mem_real && (rs == mem_rd)) ||
            (rs == wr_rd_q));
  endfunction

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    prio_d    = prio_q;
    wr_rd_d   = '0;
    wr_data_d = wr_data_q;
    cnt_d     = cnt_q;

    alu_real  = alu_valid && (alu_rd != '0);
    mem_real  = mem_valid && (mem_rd != '0);
    alu_null  = alu_valid && (alu_rd == '0);
    mem_null  = mem_valid && (mem_rd == '0);

    grant_alu = alu_real && (!mem_real || (prio_q == PRIO_ALU));
    grant_mem = mem_real && !grant_alu;

    // Writes to x0 are acknowledged and dropped without touching the pointer.
    alu_ready = reset_n && (alu_null || grant_alu);
    mem_ready = reset_n && (mem_null || grant_mem);

    if (grant_alu) begin
      prio_d    = PRIO_MEM;
      wr_rd_d   = alu_rd;
      wr_data_d = alu_data;
    end else if (grant_mem) begin
      prio_d    = PRIO_ALU;
      wr_rd_d   = mem_rd;
      wr_data_d = mem_data;
    end

    if (alu_real && mem_real && (cnt_q != '1)) cnt_d = cnt_q + 1'b1;

    hazard = rs_hazard(rs1) || rs_hazard(rs2);
  end

  // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prio_q    <= PRIO_ALU;
      wr_rd_q   <= '0;
      wr_data_q <= '0;
      cnt_q     <= '0;
    end else begin
      prio_q    <= prio_d;
      wr_rd_q   <= wr_rd_d;
      wr_data_q <= wr_data_d;
      cnt_q     <= cnt_d;
    end
  end

  assign wr_rd        = wr_rd_q;
  assign wr_data      = wr_data_q;
  assign conflict_cnt = cnt_q;

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Scoreboard bench for rf_write_arbiter: directed test-plan scenarios plus
// randomized producers, checked against a transaction-level reference model.
module tb_rf_write_arbiter;

  localparam int WD = 32;
  localparam int RB = 5;
  localparam int CB = 8;
  localparam logic [CB-1:0] CNT_MAX = '1;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          alu_valid, mem_valid;
  logic [RB-1:0] alu_rd, mem_rd, rs1, rs2;
  logic [WD-1:0] alu_data, mem_data;
  logic          alu_ready, mem_ready, hazard;
  logic [RB-1:0] wr_rd;
  logic [WD-1:0] wr_data;
  logic [CB-1:0] conflict_cnt;

  rf_write_arbiter #(.WD_SIZE(WD), .INSTR_REG_BITS(RB), .CNT_BITS(CB)) dut (
    .clk(clk), .reset_n(reset_n),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_ready(alu_ready),
    .mem_valid(mem_valid), .mem_rd(mem_rd), .mem_data(mem_data), .mem_ready(mem_ready),
    .rs1(rs1), .rs2(rs2), .hazard(hazard),
    .wr_rd(wr_rd), .wr_data(wr_data), .conflict_cnt(conflict_cnt)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  always @(posedge clk) cyc = cyc + 1;

  typedef struct {
    logic [RB-1:0] rd;
    logic [WD-1:0] data;
    int            cyc;
  } wr_t;

  wr_t exp_q[$];

  // Reference state: who has priority, what sits on the write port, conflict total.
  logic          m_prio_mem;
  logic [RB-1:0] m_wr_rd;
  int            m_cnt;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: every nonzero write must match the oldest expected write in the right cycle.
  always @(negedge clk) begin
    if (reset_n === 1'b1) begin
      while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
        check("wr_missing_rd", 64'(exp_q[0].rd), 64'(0));
        void'(exp_q.pop_front());
      end
      if (wr_rd != '0) begin
        if (exp_q.size() == 0) begin
          check("wr_unexpected", 64'(wr_rd), 64'(0));
        end else begin
          wr_t e;
          e = exp_q.pop_front();
          check("wr_cycle", 64'(cyc), 64'(e.cyc));
          check("wr_rd", 64'(wr_rd), 64'(e.rd));
          check("wr_data", 64'(wr_data), 64'(e.data));
        end
      end
    end
  end

  function automatic logic model_hazard(input logic [RB-1:0] r, input logic a_real,
                                        input logic [RB-1:0] ard, input logic m_real,
                                        input logic [RB-1:0] mrd);
    if (r == 0) return 1'b0;
    return (a_real && r == ard) || (m_real && r == mrd) || (r == m_wr_rd);
  endfunction

  // One cycle: drive requests, check combinational outputs, predict the write.
  task automatic step(input logic av, input logic [RB-1:0] ard, input logic [WD-1:0] ad,
                      input logic mv, input logic [RB-1:0] mrd, input logic [WD-1:0] md,
                      input logic [RB-1:0] r1, input logic [RB-1:0] r2,
                      output logic a_acc, output logic m_acc);
    logic a_real, m_real, win_a, win_m, exp_ar, exp_mr, exp_hz;
    @(posedge clk);
    #2;
    alu_valid = av; alu_rd = ard; alu_data = ad;
    mem_valid = mv; mem_rd = mrd; mem_data = md;
    rs1 = r1; rs2 = r2;
    #1;
    a_real = av && (ard != 0);
    m_real = mv && (mrd != 0);
    if (a_real && m_real) begin
      win_a = !m_prio_mem;
      win_m = m_prio_mem;
    end else begin
      win_a = a_real;
      win_m = m_real;
    end
    exp_ar = win_a || (av && ard == 0);
    exp_mr = win_m || (mv && mrd == 0);
    exp_hz = model_hazard(r1, a_real, ard, m_real, mrd) ||
             model_hazard(r2, a_real, ard, m_real, mrd);
    check("alu_ready", 64'(alu_ready), 64'(exp_ar));
    check("mem_ready", 64'(mem_ready), 64'(exp_mr));
    check("hazard", 64'(hazard), 64'(exp_hz));
    check("conflict_cnt", 64'(conflict_cnt), 64'(m_cnt));
    if (win_a) exp_q.push_back('{rd: ard, data: ad, cyc: cyc + 1});
    if (win_m) exp_q.push_back('{rd: mrd, data: md, cyc: cyc + 1});
    m_wr_rd = win_a ? ard : (win_m ? mrd : '0);
    if (win_a) m_prio_mem = 1'b1;
    if (win_m) m_prio_mem = 1'b0;
    if (a_real && m_real && m_cnt < int'(CNT_MAX)) m_cnt++;
    a_acc = exp_ar;
    m_acc = exp_mr;
  endtask

  task automatic idle_inputs();
    alu_valid = 0; alu_rd = 0; alu_data = 0;
    mem_valid = 0; mem_rd = 0; mem_data = 0;
    rs1 = 0; rs2 = 0;
  endtask

  task automatic model_reset();
    m_prio_mem = 1'b0;
    m_wr_rd    = '0;
    m_cnt      = 0;
    exp_q.delete();
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2;
    reset_n = 0;
    idle_inputs();
    model_reset();
    @(negedge clk);
    #2;
    reset_n = 1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic aa, ma;
    logic a_busy, m_busy;
    logic [RB-1:0] a_rd_r, m_rd_r;
    logic [WD-1:0] a_d_r, m_d_r;

    reset_n = 0;
    idle_inputs();
    model_reset();
    alu_valid = 1; alu_rd = 5;
    mem_valid = 1; mem_rd = 6;
    #12;
    check("rst_wr_rd", 64'(wr_rd), 64'(0));
    check("rst_wr_data", 64'(wr_data), 64'(0));
    check("rst_cnt", 64'(conflict_cnt), 64'(0));
    check("rst_alu_ready", 64'(alu_ready), 64'(0));
    check("rst_mem_ready", 64'(mem_ready), 64'(0));
    idle_inputs();
    @(negedge clk);
    #2;
    reset_n = 1;

    // Single ALU write: ready same cycle, visible next cycle, then gone.
    step(1, 5, 32'h1234, 0, 0, 0, 0, 0, aa, ma);
    check("a_alu_ready", 64'(alu_ready), 64'(1));
    step(0, 0, 0, 0, 0, 0, 0, 0, aa, ma);
    check("a_wr_rd", 64'(wr_rd), 64'(5));
    check("a_wr_data", 64'(wr_data), 64'(32'h1234));
    step(0, 0, 0, 0, 0, 0, 0, 0, aa, ma);
    check("a_wr_idle", 64'(wr_rd), 64'(0));

    // Two real requests: ALU first, MEM next cycle, one conflict counted.
    do_reset();
    step(1, 3, 32'hA3, 1, 7, 32'hB7, 0, 0, aa, ma);
    check("b_alu_first", 64'({alu_ready, mem_ready}), 64'(2'b10));
    step(0, 0, 0, 1, 7, 32'hB7, 0, 0, aa, ma);
    check("b_mem_second", 64'(mem_ready), 64'(1));
    check("b_wr_rd3", 64'(wr_rd), 64'(3));
    step(0, 0, 0, 0, 0, 0, 0, 0, aa, ma);
    check("b_wr_rd7", 64'(wr_rd), 64'(7));
    check("b_cnt1", 64'(conflict_cnt), 64'(1));
    // Rotate the pointer with a lone ALU grant, then the same pair favours MEM.
    step(1, 2, 32'h22, 0, 0, 0, 0, 0, aa, ma);
    step(1, 3, 32'hA3, 1, 7, 32'hB7, 0, 0, aa, ma);
    check("b_mem_first", 64'({alu_ready, mem_ready}), 64'(2'b01));
    step(1, 3, 32'hA3, 0, 0, 0, 0, 0, aa, ma);
    step(0, 0, 0, 0, 0, 0, 0, 0, aa, ma);

    // Null ALU request alongside a real MEM request.
    do_reset();
    step(1, 0, 32'hDEAD, 1, 9, 32'h99, 0, 0, aa, ma);
    check("c_both_ready", 64'({alu_ready, mem_ready}), 64'(2'b11));
    step(0, 0, 0, 0, 0, 0, 0, 0, aa, ma);
    check("c_wr_rd9", 64'(wr_rd), 64'(9));
    check("c_cnt0", 64'(conflict_cnt), 64'(0));
    step(1, 3, 32'h33, 1, 7, 32'h77, 0, 0, aa, ma);
    check("c_prio_alu", 64'(alu_ready), 64'(1));
    step(0, 0, 0, 1, 7, 32'h77, 0, 0, aa, ma);
    step(0, 0, 0, 0, 0, 0, 0, 0, aa, ma);

    // Hazards from a pending MEM write, from wr_rd, and never for x0.
    do_reset();
    step(1, 2, 32'h2, 1, 4, 32'h44, 0, 4, aa, ma);
    check("d_haz_pending", 64'(hazard), 64'(1));
    step(0, 0, 0, 1, 4, 32'h44, 0, 0, aa, ma);
    check("d_haz_x0", 64'(hazard), 64'(0));
    step(0, 0, 0, 0, 0, 0, 0, 4, aa, ma);
    check("d_haz_wr_rd", 64'(hazard), 64'(1));
    step(0, 0, 0, 0, 0, 0, 0, 4, aa, ma);
    check("d_haz_cleared", 64'(hazard), 64'(0));

    // Random producers holding requests until accepted.
    a_busy = 0; m_busy = 0;
    a_rd_r = 0; m_rd_r = 0; a_d_r = 0; m_d_r = 0;
    for (int i = 0; i < 400; i++) begin
      if (!a_busy && $urandom_range(0, 2) != 0) begin
        a_busy = 1; a_rd_r = RB'($urandom_range(0, 7)); a_d_r = $urandom;
      end
      if (!m_busy && $urandom_range(0, 2) != 0) begin
        m_busy = 1; m_rd_r = RB'($urandom_range(0, 7)); m_d_r = $urandom;
      end
      step(a_busy, a_rd_r, a_d_r, m_busy, m_rd_r, m_d_r,
           RB'($urandom_range(0, 7)), RB'($urandom_range(0, 7)), aa, ma);
      if (aa) a_busy = 0;
      if (ma) m_busy = 0;
    end
    step(0, 0, 0, 0, 0, 0, 0, 0, aa, ma);

    // Saturate the conflict counter, then reset asynchronously mid-cycle.
    do_reset();
    for (int i = 0; i < (1 << CB) + 3; i++) step(1, 3, 32'h3, 1, 7, 32'h7, 0, 0, aa, ma);
    check("e_cnt_sat", 64'(conflict_cnt), 64'(CNT_MAX));
    step(0, 0, 0, 1, 7, 32'h70, 0, 0, aa, ma);
    step(0, 0, 0, 0, 0, 0, 0, 0, aa, ma);
    check("e_wr_rd7", 64'(wr_rd), 64'(7));
    @(negedge clk);
    #2;
    alu_valid = 1; alu_rd = 5; mem_valid = 1; mem_rd = 6; rs1 = 5;
    reset_n = 0;
    #1;
    check("e_rst_wr_rd", 64'(wr_rd), 64'(0));
    check("e_rst_wr_data", 64'(wr_data), 64'(0));
    check("e_rst_cnt", 64'(conflict_cnt), 64'(0));
    check("e_rst_readies", 64'({alu_ready, mem_ready}), 64'(2'b00));
    check("e_rst_hazard", 64'(hazard), 64'(1));
    model_reset();
    idle_inputs();
    @(negedge clk);
    #2;
    reset_n = 1;
    step(1, 3, 32'h31, 1, 7, 32'h71, 0, 0, aa, ma);
    check("e_post_rst_alu", 64'(alu_ready), 64'(1));
    step(0, 0, 0, 1, 7, 32'h71, 0, 0, aa, ma);
    step(0, 0, 0, 0, 0, 0, 0, 0, aa, ma);
    step(0, 0, 0, 0, 0, 0, 0, 0, aa, ma);
    @(negedge clk);
    #1;
    check("q_drained", 64'(exp_q.size()), 64'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
